// File: rtl/cfg_apb_sequencer_pkg.sv
// Purpose: shared op codes, FSM encodings and register map for the APB config sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: address/data widths, register addresses of the config slave, op/state/phase enums.
package cfg_apb_sequencer_pkg;

  localparam int REG_ADDRWIDTH = 8;
  localparam int REG_DATAWIDTH = 32;

  // Register map of the configuration slave
  localparam logic [REG_ADDRWIDTH-1:0] REG_STDN_TPU_ADDR   = 8'h00;
  localparam logic [REG_ADDRWIDTH-1:0] REG_MATRIX_A_ADDR   = 8'h04;
  localparam logic [REG_ADDRWIDTH-1:0] REG_MATRIX_B_ADDR   = 8'h08;
  localparam logic [REG_ADDRWIDTH-1:0] REG_MATRIX_C_ADDR   = 8'h0C;
  localparam logic [REG_ADDRWIDTH-1:0] REG_BATCH_SIZE_ADDR = 8'h10;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_DELAY = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_CHECK  = 3'd3,
    ST_GAP    = 3'd4,
    ST_DELAY  = 3'd5,
    ST_RESP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2,
    PH_CHECK  = 2'd3
  } phase_e;

endpackage

// File: rtl/cfg_apb_master_if.sv
// Purpose: drives one APB transfer (SETUP, ACCESS, then CHECK with PSEL low) per start pulse.
// Latency: start -> done 3 cycles; done is high in the CHECK cycle, where PREADY/PRDATA are sampled.
// Backpressure: none; a start is only honoured while idle, the caller must not issue overlapping starts.
// Ports: i_start/i_write/i_addr/i_wdata request; o_done/o_ready_seen/o_rdata result; o_p*/i_p* APB bus.
module cfg_apb_master_if
  import cfg_apb_sequencer_pkg::*;
#(
  parameter int ADDR_W = REG_ADDRWIDTH,
  parameter int DATA_W = REG_DATAWIDTH
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_done,
  output logic              o_ready_seen,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_pwrite,
  output logic              o_psel,
  output logic              o_penable,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready
);

  phase_e            r_phase;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic              r_psel;
  logic              r_penable;
  logic [DATA_W-1:0] r_pwdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase   <= PH_IDLE;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwdata  <= '0;
    end else begin
      case (r_phase)
        PH_IDLE: begin
          if (i_start) begin
            r_phase   <= PH_SETUP;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_paddr   <= i_addr;
            r_pwrite  <= i_write;
            r_pwdata  <= i_write ? i_wdata : '0;
          end
        end
        PH_SETUP: begin
          r_phase   <= PH_ACCESS;
          r_penable <= 1'b1;
        end
        PH_ACCESS: begin
          // PSEL must fall here: the slave re-triggers on a held PSEL.
          r_phase   <= PH_CHECK;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
        PH_CHECK: r_phase <= PH_IDLE;
        default:  r_phase <= PH_IDLE;
      endcase
    end
  end

  // The slave answers one cycle after ACCESS, so its response is live during CHECK.
  assign o_done       = (r_phase == PH_CHECK);
  assign o_ready_seen = o_done && i_pready;
  assign o_rdata      = i_prdata;

  assign o_paddr   = r_paddr;
  assign o_pwrite  = r_pwrite;
  assign o_psel    = r_psel;
  assign o_penable = r_penable;
  assign o_pwdata  = r_pwdata;

endmodule

// File: rtl/cfg_apb_sequencer.sv
// Purpose: executes WRITE/READ/POLL/DELAY descriptors against the config slave over APB, one at a time.
// Latency: WRITE/READ accept -> rsp_valid 4 cycles; POLL re-reads every 3+POLL_GAP cycles; DELAY N -> N+1.
// Backpressure: cmd_ready only in IDLE; rsp_valid held with stable data until rsp_ready.
// Ports: i_cmd_* command in, o_rsp_* response out, o_busy status, o_p*/i_p* APB master bus.
module cfg_apb_sequencer
  import cfg_apb_sequencer_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDRWIDTH,
  parameter int DATA_W     = REG_DATAWIDTH,
  parameter int POLL_GAP   = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_error,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_pwrite,
  output logic              o_psel,
  output logic              o_penable,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready
);

  localparam logic [15:0]       GAP_LAST = 16'(POLL_GAP - 1);
  localparam logic [15:0]       POLL_MAX = 16'(POLL_LIMIT);
  localparam logic [DATA_W-1:0] DLY_ONE  = DATA_W'(1);

  state_e            r_state;
  op_e               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_poll_cnt;
  logic [15:0]       r_gap_cnt;
  logic [DATA_W-1:0] r_dly_cnt;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_error;

  op_e               w_cmd_op;
  logic              w_cmd_ready;
  logic              w_accept;
  logic              w_gap_done;
  logic              w_start;
  logic              w_start_write;
  logic [ADDR_W-1:0] w_start_addr;
  logic              w_done;
  logic              w_ready_seen;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_rsp_rdata;
  logic [15:0]       w_poll_next;
  logic              w_poll_hit;

  assign w_cmd_op    = op_e'(i_cmd_op);
  // Gated by reset so the host never sees ready while reset is held.
  assign w_cmd_ready = (r_state == ST_IDLE) && !i_reset;
  assign w_accept    = i_cmd_valid && w_cmd_ready;
  assign w_gap_done  = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);

  // A transfer starts either from a freshly accepted command or from the end of a poll gap.
  assign w_start       = (w_accept && (w_cmd_op != OP_DELAY)) || w_gap_done;
  assign w_start_write = w_accept && (w_cmd_op == OP_WRITE);
  assign w_start_addr  = w_accept ? i_cmd_addr : r_addr;

  assign w_rsp_rdata = (r_op == OP_WRITE) ? '0 : w_rdata;
  assign w_poll_next = r_poll_cnt + 16'd1;
  assign w_poll_hit  = (w_rdata & r_data) != '0;

  cfg_apb_master_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_master (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (w_start),
    .i_write      (w_start_write),
    .i_addr       (w_start_addr),
    .i_wdata      (i_cmd_data),
    .o_done       (w_done),
    .o_ready_seen (w_ready_seen),
    .o_rdata      (w_rdata),
    .o_paddr      (o_paddr),
    .o_pwrite     (o_pwrite),
    .o_psel       (o_psel),
    .o_penable    (o_penable),
    .o_pwdata     (o_pwdata),
    .i_prdata     (i_prdata),
    .i_pready     (i_pready)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_WRITE;
      r_addr      <= '0;
      r_data      <= '0;
      r_poll_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_dly_cnt   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op       <= w_cmd_op;
            r_addr     <= i_cmd_addr;
            r_data     <= i_cmd_data;
            r_poll_cnt <= '0;
            if (w_cmd_op == OP_DELAY) begin
              r_dly_cnt <= i_cmd_data;
              if (i_cmd_data == '0) begin
                r_state     <= ST_RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= '0;
                r_rsp_error <= 1'b0;
              end else begin
                r_state <= ST_DELAY;
              end
            end else begin
              r_state <= ST_SETUP;
            end
          end
        end
        ST_SETUP:  r_state <= ST_ACCESS;
        ST_ACCESS: r_state <= ST_CHECK;
        ST_CHECK: begin
          if (w_done) begin
            if (!w_ready_seen) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_rsp_rdata;
              r_rsp_error <= 1'b1;
            end else if ((r_op == OP_POLL) && !w_poll_hit) begin
              // Keep the last read value so a timeout reports what the register held.
              r_poll_cnt <= w_poll_next;
              r_rsp_data <= w_rdata;
              if (w_poll_next == POLL_MAX) begin
                r_state     <= ST_RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_error <= 1'b1;
              end else begin
                r_state   <= ST_GAP;
                r_gap_cnt <= '0;
              end
            end else begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= w_rsp_rdata;
              r_rsp_error <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (w_gap_done) begin
            r_state   <= ST_SETUP;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 16'd1;
          end
        end
        ST_DELAY: begin
          // Leaving when the count reads 1 gives exactly N cycles in this state.
          if (r_dly_cnt == DLY_ONE) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
          end else begin
            r_dly_cnt <= r_dly_cnt - DLY_ONE;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_poll_cnt  <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = w_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_error = r_rsp_error;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_cfg_apb_sequencer.sv
// Purpose: directed self-checking bench for cfg_apb_sequencer with a behavioural config slave.
// Latency: slave pulses PREADY the cycle after ACCESS, as the real slave does.
// Backpressure: rsp_ready driven per scenario.
module tb_cfg_apb_sequencer;
  import cfg_apb_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_addr = 8'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        busy;
  logic [7:0]  paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'd0;
  logic        pready = 1'b0;

  logic        done_tpu = 1'b0;
  logic        drop_pready = 1'b0;
  logic [31:0] regs [0:255];
  int          xfer_cnt = 0;
  int          read_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  cfg_apb_sequencer #(
    .ADDR_W     (8),
    .DATA_W     (32),
    .POLL_GAP   (4),
    .POLL_LIMIT (8)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_data  (cmd_data),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_error (rsp_error),
    .o_busy      (busy),
    .o_paddr     (paddr),
    .o_pwrite    (pwrite),
    .o_psel      (psel),
    .o_penable   (penable),
    .o_pwdata    (pwdata),
    .i_prdata    (prdata),
    .i_pready    (pready)
  );

  // Config slave model: acts on ACCESS, answers one cycle later; STDN bit31 mirrors done_tpu.
  always @(posedge clk) begin
    if (reset) begin
      pready <= 1'b0;
      prdata <= 32'd0;
      for (int i = 0; i < 256; i++) regs[i] <= 32'd0;
    end else begin
      pready <= psel && penable && !drop_pready;
      if (psel && penable) begin
        xfer_cnt <= xfer_cnt + 1;
        if (pwrite) begin
          regs[paddr] <= pwdata;
        end else begin
          prdata   <= regs[paddr] | (((paddr == REG_STDN_TPU_ADDR) && done_tpu) ? 32'h8000_0000 : 32'h0);
          read_cnt <= read_cnt + 1;
        end
      end
    end
  end

  // Drive a command for one cycle starting at the current negedge; returns at the next negedge.
  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts negedges since accept until rsp_valid; -1 if the budget runs out.
  task automatic wait_rsp(input int start, output int cyc);
    cyc = start;
    while (!rsp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!rsp_valid) cyc = -1;
  endtask

  task automatic handshake;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
    n_cmp++; if ({psel, penable} !== 2'b00) begin n_bad++; $display("FAIL reset_psel_pen got %b want 00", {psel, penable}); end
    n_cmp++; if ({rsp_valid, rsp_error, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_rsp_busy got %b want 000", {rsp_valid, rsp_error, busy}); end
    n_cmp++; if (rsp_data !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_write;
    int       base;
    logic [3:0] ps, pe, rv;
    base = xfer_cnt;
    ps = '0; pe = '0; rv = '0;
    send(OP_WRITE, REG_MATRIX_A_ADDR, 32'h40);
    n_cmp++; if ({paddr, pwrite, pwdata} !== {REG_MATRIX_A_ADDR, 1'b1, 32'h40}) begin n_bad++; $display("FAIL wr_setup_bus got %h/%b/%h want %h/1/00000040", paddr, pwrite, pwdata, REG_MATRIX_A_ADDR); end
    n_cmp++; if ({cmd_ready, busy} !== 2'b01) begin n_bad++; $display("FAIL wr_busy got rdy=%b busy=%b want 0/1", cmd_ready, busy); end
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      ps = {ps[2:0], psel};
      pe = {pe[2:0], penable};
      rv = {rv[2:0], rsp_valid};
    end
    n_cmp++; if (ps !== 4'b1100) begin n_bad++; $display("FAIL wr_psel_trace got %b want 1100", ps); end
    n_cmp++; if (pe !== 4'b0100) begin n_bad++; $display("FAIL wr_penable_trace got %b want 0100", pe); end
    n_cmp++; if (rv !== 4'b0001) begin n_bad++; $display("FAIL wr_rsp_valid_trace got %b want 0001", rv); end
    n_cmp++; if ({rsp_error, rsp_data} !== 33'd0) begin n_bad++; $display("FAIL wr_rsp got err=%b data=%h want 0/0", rsp_error, rsp_data); end
    n_cmp++; if (regs[REG_MATRIX_A_ADDR] !== 32'h40) begin n_bad++; $display("FAIL wr_slave_reg got %h want 40", regs[REG_MATRIX_A_ADDR]); end
    n_cmp++; if (xfer_cnt - base !== 1) begin n_bad++; $display("FAIL wr_xfers got %0d want 1", xfer_cnt - base); end
    handshake();
  endtask

  task automatic test_write_read;
    int base, base_r, cyc;
    base = xfer_cnt; base_r = read_cnt;
    send(OP_WRITE, REG_BATCH_SIZE_ADDR, 32'd7);
    wait_rsp(1, cyc);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL wr2_latency got %0d want 4", cyc); end
    handshake();
    send(OP_READ, REG_BATCH_SIZE_ADDR, 32'd0);
    wait_rsp(1, cyc);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL rd_latency got %0d want 4", cyc); end
    n_cmp++; if ({rsp_error, rsp_data} !== {1'b0, 32'd7}) begin n_bad++; $display("FAIL rd_rsp got err=%b data=%h want 0/7", rsp_error, rsp_data); end
    n_cmp++; if (xfer_cnt - base !== 2) begin n_bad++; $display("FAIL wr_rd_xfers got %0d want 2", xfer_cnt - base); end
    n_cmp++; if (read_cnt - base_r !== 1) begin n_bad++; $display("FAIL wr_rd_reads got %0d want 1", read_cnt - base_r); end
    handshake();
  endtask

  task automatic test_poll_done;
    int base_r, cyc;
    send(OP_WRITE, REG_STDN_TPU_ADDR, 32'd1);
    wait_rsp(1, cyc);
    handshake();
    base_r = read_cnt;
    send(OP_POLL, REG_STDN_TPU_ADDR, 32'h8000_0000);
    cyc = 1;
    while (!rsp_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 20) done_tpu = 1'b1;
    end
    n_cmp++; if (cyc !== 25) begin n_bad++; $display("FAIL poll_latency got %0d want 25", cyc); end
    n_cmp++; if ({rsp_error, rsp_data} !== {1'b0, 32'h8000_0001}) begin n_bad++; $display("FAIL poll_rsp got err=%b data=%h want 0/80000001", rsp_error, rsp_data); end
    n_cmp++; if (read_cnt - base_r !== 4) begin n_bad++; $display("FAIL poll_reads got %0d want 4", read_cnt - base_r); end
    handshake();
  endtask

  task automatic test_poll_timeout;
    int base_r, cyc;
    done_tpu = 1'b0;
    base_r = read_cnt;
    send(OP_POLL, REG_STDN_TPU_ADDR, 32'h8000_0000);
    wait_rsp(1, cyc);
    n_cmp++; if (cyc !== 53) begin n_bad++; $display("FAIL poll_to_latency got %0d want 53", cyc); end
    n_cmp++; if ({rsp_error, rsp_data} !== {1'b1, 32'd1}) begin n_bad++; $display("FAIL poll_to_rsp got err=%b data=%h want 1/1", rsp_error, rsp_data); end
    n_cmp++; if (read_cnt - base_r !== 8) begin n_bad++; $display("FAIL poll_to_reads got %0d want 8", read_cnt - base_r); end
    handshake();
    // Zero mask on a non-zero register must still time out.
    base_r = read_cnt;
    send(OP_POLL, REG_BATCH_SIZE_ADDR, 32'd0);
    wait_rsp(1, cyc);
    n_cmp++; if (cyc !== 53) begin n_bad++; $display("FAIL poll_mask0_latency got %0d want 53", cyc); end
    n_cmp++; if ({rsp_error, rsp_data} !== {1'b1, 32'd7}) begin n_bad++; $display("FAIL poll_mask0_rsp got err=%b data=%h want 1/7", rsp_error, rsp_data); end
    n_cmp++; if (read_cnt - base_r !== 8) begin n_bad++; $display("FAIL poll_mask0_reads got %0d want 8", read_cnt - base_r); end
    handshake();
  endtask

  task automatic test_no_ready;
    int cyc;
    drop_pready = 1'b1;
    send(OP_READ, REG_BATCH_SIZE_ADDR, 32'd0);
    wait_rsp(1, cyc);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL noready_latency got %0d want 4", cyc); end
    n_cmp++; if (rsp_error !== 1'b1) begin n_bad++; $display("FAIL noready_error got %b want 1", rsp_error); end
    handshake();
    drop_pready = 1'b0;
  endtask

  task automatic test_delay;
    int cyc;
    send(OP_DELAY, 8'd0, 32'd10);
    n_cmp++; if ({cmd_ready, busy, psel} !== 3'b010) begin n_bad++; $display("FAIL dly_state got %b want 010", {cmd_ready, busy, psel}); end
    wait_rsp(1, cyc);
    n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL dly_latency got %0d want 11", cyc); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({rsp_valid, cmd_ready, rsp_error, rsp_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
        n_bad++; $display("FAIL dly_hold%0d got v=%b rdy=%b e=%b d=%h want 1/0/0/0", i, rsp_valid, cmd_ready, rsp_error, rsp_data);
      end
      @(negedge clk);
    end
    handshake();
    n_cmp++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_bad++; $display("FAIL dly_after got %b want 10", {cmd_ready, rsp_valid}); end
    send(OP_DELAY, 8'd0, 32'd0);
    wait_rsp(1, cyc);
    n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL dly0_latency got %0d want 1", cyc); end
    handshake();
  endtask

  task automatic test_back_to_back;
    int base, ns, nhi;
    int s [0:3];
    base = xfer_cnt; ns = 0; nhi = 0;
    for (int i = 0; i < 4; i++) s[i] = -1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = REG_MATRIX_B_ADDR; cmd_data = 32'h11;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (psel) nhi++;
      if (psel && !penable && ns < 4) begin s[ns] = k; ns++; end
      if (k == 14) cmd_valid = 1'b0;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++; if (ns !== 3) begin n_bad++; $display("FAIL b2b_setups got %0d want 3", ns); end
    n_cmp++; if ({s[0], s[1], s[2]} !== {32'sd1, 32'sd6, 32'sd11}) begin n_bad++; $display("FAIL b2b_cadence got %0d,%0d,%0d want 1,6,11", s[0], s[1], s[2]); end
    n_cmp++; if (nhi !== 6) begin n_bad++; $display("FAIL b2b_psel_cycles got %0d want 6", nhi); end
    n_cmp++; if (xfer_cnt - base !== 3) begin n_bad++; $display("FAIL b2b_xfers got %0d want 3", xfer_cnt - base); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int cyc, seen;
    send(OP_WRITE, REG_BATCH_SIZE_ADDR, 32'h55);
    @(negedge clk);
    n_cmp++; if ({psel, penable} !== 2'b11) begin n_bad++; $display("FAIL rstmid_access got %b want 11", {psel, penable}); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({psel, penable, rsp_valid, busy, cmd_ready} !== 5'b00000) begin n_bad++; $display("FAIL rstmid_drop got %b want 00000", {psel, penable, rsp_valid, busy, cmd_ready}); end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || psel) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rstmid_quiet got %0d active cycles want 0", seen); end
    n_cmp++; if (regs[REG_BATCH_SIZE_ADDR] !== 32'd0) begin n_bad++; $display("FAIL rstmid_no_write got %h want 0", regs[REG_BATCH_SIZE_ADDR]); end
    send(OP_WRITE, REG_BATCH_SIZE_ADDR, 32'h99);
    wait_rsp(1, cyc);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL rstmid_next_latency got %0d want 4", cyc); end
    n_cmp++; if ({rsp_error, regs[REG_BATCH_SIZE_ADDR]} !== {1'b0, 32'h99}) begin n_bad++; $display("FAIL rstmid_next got err=%b reg=%h want 0/99", rsp_error, regs[REG_BATCH_SIZE_ADDR]); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_write();
    test_write_read();
    test_poll_done();
    test_poll_timeout();
    test_no_ready();
    test_delay();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
